// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Define BTB_BYPASS_EN to forward a same-index update into this cycle's lookup.
module branch_target_predictor #(
  parameter int WIDTH   = 16,
  parameter int ENTRIES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fetch_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic             upd_taken,
  input  logic [WIDTH-1:0] upd_target,
  output logic [15:0]      mispredict_count
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = WIDTH - 1 - IDX;

  logic             valid_q  [ENTRIES];
  logic [TAGW-1:0]  tag_q    [ENTRIES];
  logic [WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [15:0]      mispredict_count_q, mispredict_count_d;

  logic [IDX-1:0]   upd_idx, fetch_idx;
  logic [TAGW-1:0]  upd_tag, fetch_tag;

  logic             upd_hit, prior_taken, mispredict, entry_we;
  logic             entry_valid_d;
  logic [TAGW-1:0]  entry_tag_d;
  logic [WIDTH-1:0] entry_target_d;
  logic [1:0]       entry_ctr_d;

  logic             look_valid;
  logic [TAGW-1:0]  look_tag;
  logic [WIDTH-1:0] look_target;
  logic [1:0]       look_ctr;

  // Instructions are word-aligned, so the low PC bit carries no information.
  logic unused_pc_lsb;
  assign unused_pc_lsb = fetch_pc[0] ^ upd_pc[0];

  assign upd_idx   = upd_pc[IDX:1];
  assign upd_tag   = upd_pc[WIDTH-1:IDX+1];
  assign fetch_idx = fetch_pc[IDX:1];
  assign fetch_tag = fetch_pc[WIDTH-1:IDX+1];

  // The *_d entry values are the indexed entry as it will look after this edge.
  always_comb begin
    upd_hit        = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    prior_taken    = upd_hit && ctr_q[upd_idx][1];
    entry_we       = 1'b0;
    entry_valid_d  = valid_q[upd_idx];
    entry_tag_d    = tag_q[upd_idx];
    entry_target_d = target_q[upd_idx];
    entry_ctr_d    = ctr_q[upd_idx];
    if (upd_valid) begin
      if (upd_hit) begin
        entry_we = 1'b1;
        if (upd_taken) begin
          entry_ctr_d    = (ctr_q[upd_idx] != 2'b11) ? ctr_q[upd_idx] + 2'd1 : 2'b11;
          entry_target_d = upd_target;
        end else begin
          entry_ctr_d = (ctr_q[upd_idx] != 2'b00) ? ctr_q[upd_idx] - 2'd1 : 2'b00;
        end
      end else if (upd_taken) begin
        entry_we       = 1'b1;
        entry_valid_d  = 1'b1;
        entry_tag_d    = upd_tag;
        entry_target_d = upd_target;
        entry_ctr_d    = 2'b10;
      end
    end
    mispredict = upd_valid &&
                 ((prior_taken != upd_taken) ||
                  (prior_taken && (target_q[upd_idx] != upd_target)));
    mispredict_count_d = mispredict_count_q;
    if (mispredict && (mispredict_count_q != 16'hFFFF)) begin
      mispredict_count_d = mispredict_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
      mispredict_count_q <= 16'd0;
    end else begin
      if (entry_we) begin
        valid_q[upd_idx]  <= entry_valid_d;
        tag_q[upd_idx]    <= entry_tag_d;
        target_q[upd_idx] <= entry_target_d;
        ctr_q[upd_idx]    <= entry_ctr_d;
      end
      mispredict_count_q <= mispredict_count_d;
    end
  end

  always_comb begin
    look_valid  = valid_q[fetch_idx];
    look_tag    = tag_q[fetch_idx];
    look_target = target_q[fetch_idx];
    look_ctr    = ctr_q[fetch_idx];
`ifdef BTB_BYPASS_EN
    if (upd_valid && (upd_idx == fetch_idx)) begin
      look_valid  = entry_valid_d;
      look_tag    = entry_tag_d;
      look_target = entry_target_d;
      look_ctr    = entry_ctr_d;
    end
`endif
    pred_hit    = look_valid && (look_tag == fetch_tag);
    pred_taken  = pred_hit && look_ctr[1];
    pred_target = pred_hit ? look_target : fetch_pc + WIDTH'(2);
  end

  assign mispredict_count = mispredict_count_q;

endmodule
